divider_pipelined: RTL and testbench
====================================

# divider_pipelined

Fully pipelined unsigned restoring array divider. It is the inverse companion of the team's pipelined array multiplier, with one quotient bit resolved per pipeline stage. It accepts a new dividend/divisor pair every clock cycle and returns quotient, remainder and a divide-by-zero flag a fixed `width` cycles later. Valid tags travel with the data so that downstream logic can consume results without external bookkeeping.

## Interface
- `width`, default 32: operand width in bits; dividend, divisor, quotient and remainder are all `width` bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: qualifies `a`/`b` on the current edge.
- `a` input `width`: dividend, unsigned.
- `b` input `width`: divisor, unsigned.
- `out_valid` output 1: qualifies `q`, `r` and `dbz`.
- `q` output `width`: quotient, floor(a/b).
- `r` output `width`: remainder, a − q·b.
- `dbz` output 1: divide-by-zero flag, set when the sampled `b` was 0.

## Operation
- No backpressure. The block accepts an operation on every edge where `in_valid`=1; there is no ready signal.
- Stage 0 (input register): captures `a`, `b` and `in_valid`.
  - Sets the partial remainder to 0 and the partial quotient to 0.
  - Sets `dbz` = (b==0).
- Stages k = 1..width: each registered stage carries dividend, divisor, partial remainder, partial quotient, valid and dbz. Stage k resolves quotient bit i = width−k:
  - T = {R, a[i]}, with T being width+1 bits.
  - If T ≥ {1'b0, b}: R ← T − b and q[i] ← 1.
  - Otherwise: R ← T[width−1:0] and q[i] ← 0.
  - All other q bits pass through unchanged.
- Width rules:
  - The trial subtraction is width+1 bits wide.
  - The stored remainder is always < b (for b≠0), so it fits in `width` bits.
  - No truncation of the quotient.
- Divide by zero: no special datapath. Every trial subtraction succeeds, which naturally produces q = all ones and r = a. `dbz`=1 is carried along in the pipeline. This result is required and must be checked exactly.
- Outputs `q`, `r`, `dbz` and `out_valid` are driven directly from the stage-`width` registers.
- When a stage's valid bit is 0, its data registers may still update (don't-care). Only `out_valid` has meaning for the consumer.
- Reset, asserted at any time, asynchronously clears all of the following:
  - every valid bit;
  - every partial remainder and partial quotient;
  - every dbz bit;
  - the captured operands.

  In-flight operations are discarded and are never reported.
- Reset values: `out_valid`=0, `q`=0, `r`=0, `dbz`=0.

## Timing
- Latency: operands sampled at rising edge N with `in_valid`=1 appear on the outputs with `out_valid`=1 immediately after edge N+width, and hold until edge N+width+1.
- Throughput: one result per cycle. A gap of G cycles in `in_valid` reappears as exactly G cycles of `out_valid`=0 at the output. Ordering is strictly preserved.
- `rst` deassertion: the first edge at which `in_valid` is sampled is the first rising edge with `rst` low. The earliest `out_valid` is therefore `width` edges later.
- `rst` asserted mid-stream:
  - Outputs clear within the same cycle, without waiting for an edge.
  - Inputs presented while `rst`=1 are ignored.
- No combinational path from inputs to outputs.
- Critical path: one width+1-bit subtract-and-mux per stage.

## Test plan
All scenarios run at `width`=8 unless noted; latency is 8 edges.
- Reset: hold `rst`=1 while driving `in_valid`=1, a=9, b=3 → `out_valid`, `q`, `r`, `dbz` stay 0 throughout. After release, a=9, b=3 sampled at edge N → q=3, r=0, dbz=0, valid exactly after edge N+8.
- Basic arithmetic, one operation per cycle:
  - 100/7 → q=14, r=2.
  - 255/1 → q=255, r=0.
  - 0/5 → q=0, r=0.
  - 7/200 → q=0, r=7.
  - 255/255 → q=1, r=0.

  Results must appear in consecutive cycles.
- Divide by zero: 200/0 → q=255, r=200, dbz=1. The next operation, 10/3, → q=3, r=1, dbz=0.
- Bubbles: `in_valid` pattern 1,0,0,1,1,0,1 with distinct operands → `out_valid` pattern is identical, shifted by 8 cycles, with correct results in the same order.
- Reset mid-stream: issue 5 operations on consecutive edges, assert `rst` asynchronously (mid-cycle) after the third edge, then release and issue 50/6 → none of the first 5 results ever appear. `out_valid` drops immediately. The only result is q=8, r=2.
- Random regression, repeated at `width`=32: 10,000 random pairs including b=0, b=1 and a<b cases → for b≠0, q·b + r == a and r < b; for b=0, q = all ones, r = a and dbz=1. Compare against a reference model at the 32-cycle latency.

Source files
------------

// File: rtl/divider_pipelined.sv
// divider_pipelined
//
// Fully pipelined unsigned restoring array divider. A new dividend/divisor pair
// may enter on every clock edge. Stage k (k = 1..width) resolves quotient bit
// width-k, so results emerge exactly `width` edges after the operands were
// sampled. A valid tag and a divide-by-zero flag ride alongside the data.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears every stage
//   in_valid   qualifies a/b on the current edge
//   a          dividend (unsigned, width bits)
//   b          divisor  (unsigned, width bits)
//   out_valid  qualifies q/r/dbz
//   q          quotient  floor(a/b); all ones when b == 0
//   r          remainder a - q*b;    equals a when b == 0
//   dbz        set when the sampled divisor was zero

module divider_pipelined #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic             out_valid,
    output logic [width-1:0] q,
    output logic [width-1:0] r,
    output logic             dbz
);

    // Operands are only needed up to the last stage's input (index width-1).
    logic [width-1:0] a_s   [0:width-1];
    logic [width-1:0] b_s   [0:width-1];
    logic [width-1:0] rem_s [0:width];
    logic [width-1:0] quo_s [0:width];
    logic             val_s [0:width];
    logic             dbz_s [0:width];

    // Next-state values for stages 1..width.
    logic [width:0]   trial [1:width];
    logic [width-1:0] rem_d [1:width];
    logic [width-1:0] quo_d [1:width];
    logic [width:1]   ge;

    always_comb begin
        for (int unsigned k = 1; k <= width; k++) begin
            // Shift the next dividend bit into the partial remainder.
            trial[k] = {rem_s[k-1], a_s[k-1][width-k]};
            ge[k]    = (trial[k] >= {1'b0, b_s[k-1]});
            // The difference is < b whenever it is taken, so width bits suffice.
            // With b == 0 every trial succeeds, giving q = all ones and r = a.
            rem_d[k] = ge[k] ? (trial[k][width-1:0] - b_s[k-1]) : trial[k][width-1:0];
            quo_d[k] = quo_s[k-1];
            quo_d[k][width-k] = ge[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < width; k++) begin
                a_s[k] <= '0;
                b_s[k] <= '0;
            end
            for (int unsigned k = 0; k <= width; k++) begin
                rem_s[k] <= '0;
                quo_s[k] <= '0;
                val_s[k] <= 1'b0;
                dbz_s[k] <= 1'b0;
            end
        end else begin
            // Stage 0: input capture.
            a_s[0]   <= a;
            b_s[0]   <= b;
            rem_s[0] <= '0;
            quo_s[0] <= '0;
            val_s[0] <= in_valid;
            dbz_s[0] <= (b == '0);
            for (int unsigned k = 1; k < width; k++) begin
                a_s[k] <= a_s[k-1];
                b_s[k] <= b_s[k-1];
            end
            for (int unsigned k = 1; k <= width; k++) begin
                rem_s[k] <= rem_d[k];
                quo_s[k] <= quo_d[k];
                val_s[k] <= val_s[k-1];
                dbz_s[k] <= dbz_s[k-1];
            end
        end
    end

    assign out_valid = val_s[width];
    assign q         = quo_s[width];
    assign r         = rem_s[width];
    assign dbz       = dbz_s[width];

endmodule

// File: tb/tb_divider_pipelined.sv
// Scoreboard bench for divider_pipelined. Two instances: width 8 for directed
// vectors with hand-computed results, width 32 for a random regression checked
// against the bench's own divide model. The driver pushes each expectation with
// the edge at which its operands are sampled; monitors pop on out_valid and check
// result values and latency.

module tb_divider_pipelined;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          edge_no;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        out_valid8;
    logic [7:0]  q8, r8;
    logic        dbz8;

    logic        in_valid32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        out_valid32;
    logic [31:0] q32, r32;
    logic        dbz32;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    exp_t sb8[$];
    exp_t sb32[$];

    divider_pipelined #(.width(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .a(a8), .b(b8),
        .out_valid(out_valid8), .q(q8), .r(r8), .dbz(dbz8)
    );

    divider_pipelined #(.width(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .a(a32), .b(b32),
        .out_valid(out_valid32), .q(q32), .r(r32), .dbz(dbz32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (out_valid8 !== 1'b0 || q8 !== 8'd0 || r8 !== 8'd0 || dbz8 !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold8: got v=%b q=%0d r=%0d dbz=%b, want all zero",
                         out_valid8, q8, r8, dbz8);
            end
        end else if (out_valid8 === 1'b1) begin
            checks++;
            if (sb8.size() == 0) begin
                failures++;
                $display("FAIL unexpected8: got q=%0d r=%0d at edge %0d, want no result",
                         q8, r8, edge_cnt);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                if (q8 !== e.q[7:0] || r8 !== e.r[7:0] || dbz8 !== e.dbz
                    || edge_cnt != e.edge_no + 8) begin
                    failures++;
                    $display("FAIL result8: got q=%0d r=%0d dbz=%b edge=%0d, want q=%0d r=%0d dbz=%b edge=%0d",
                             q8, r8, dbz8, edge_cnt, e.q[7:0], e.r[7:0], e.dbz, e.edge_no + 8);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid32 === 1'b1) begin
            checks++;
            if (sb32.size() == 0) begin
                failures++;
                $display("FAIL unexpected32: got q=%0h r=%0h, want no result", q32, r32);
            end else begin
                exp_t e;
                e = sb32.pop_front();
                if (q32 !== e.q || r32 !== e.r || dbz32 !== e.dbz
                    || edge_cnt != e.edge_no + 32) begin
                    failures++;
                    $display("FAIL result32: got q=%0h r=%0h dbz=%b edge=%0d, want q=%0h r=%0h dbz=%b edge=%0d",
                             q32, r32, dbz32, edge_cnt, e.q, e.r, e.dbz, e.edge_no + 32);
                end
            end
        end
    end

    // Drive at a falling edge; operands are sampled at the next rising edge.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] qe, input logic [7:0] re, input logic de,
                          input bit push);
        exp_t e;
        in_valid8 = 1'b1;
        a8 = av;
        b8 = bv;
        e.q = {24'd0, qe};
        e.r = {24'd0, re};
        e.dbz = de;
        e.edge_no = edge_cnt + 1;
        if (push) sb8.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle8(input int n);
        in_valid8 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic issue32(input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        in_valid32 = 1'b1;
        a32 = av;
        b32 = bv;
        if (bv == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = av;
            e.dbz = 1'b1;
        end else begin
            e.q = av / bv;
            e.r = av % bv;
            e.dbz = 1'b0;
        end
        e.edge_no = edge_cnt + 1;
        sb32.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb8.size() != 0 || sb32.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb8.size() != 0 || sb32.size() != 0) begin
            failures++;
            $display("FAIL drain_%s: got %0d/%0d results outstanding, want 0",
                     name, sb8.size(), sb32.size());
        end
    endtask

    logic [7:0] fa [0:7] = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
    logic [7:0] fb [0:7] = '{8'd2,  8'd5,  8'd4,  8'd3,  8'd6,  8'd7,  8'd8,  8'd5};
    logic [7:0] fq [0:7] = '{8'd5,  8'd2,  8'd3,  8'd4,  8'd2,  8'd2,  8'd2,  8'd3};
    logic [7:0] fr [0:7] = '{8'd1,  8'd2,  8'd1,  8'd2,  8'd3,  8'd2,  8'd1,  8'd3};

    initial begin
        // Reset held with live inputs: monitor checks outputs stay zero.
        in_valid8 = 1'b1;
        a8 = 8'd9;
        b8 = 8'd3;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        issue8(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b1);
        idle8(2);

        // Back-to-back arithmetic.
        issue8(8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 1'b1);
        issue8(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 1'b1);
        issue8(8'd0,   8'd5,   8'd0,   8'd0, 1'b0, 1'b1);
        issue8(8'd7,   8'd200, 8'd0,   8'd7, 1'b0, 1'b1);
        issue8(8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 1'b1);

        // Divide by zero followed by a normal operation.
        issue8(8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 1'b1);
        issue8(8'd10,  8'd3, 8'd3,   8'd1,   1'b0, 1'b1);
        idle8(1);

        // Bubble pattern 1,0,0,1,1,0,1.
        issue8(8'd50,  8'd7,  8'd7,  8'd1,  1'b0, 1'b1);
        idle8(2);
        issue8(8'd99,  8'd10, 8'd9,  8'd9,  1'b0, 1'b1);
        issue8(8'd128, 8'd3,  8'd42, 8'd2,  1'b0, 1'b1);
        idle8(1);
        issue8(8'd250, 8'd16, 8'd15, 8'd10, 1'b0, 1'b1);
        idle8(1);
        drain("directed");

        // Mid-stream reset: eight fillers keep the output busy, then five more.
        for (int i = 0; i < 8; i++) issue8(fa[i], fb[i], fq[i], fr[i], 1'b0, 1'b1);
        issue8(8'd60, 8'd7, 8'd8,  8'd4, 1'b0, 1'b1);
        issue8(8'd61, 8'd6, 8'd10, 8'd1, 1'b0, 1'b1);
        in_valid8 = 1'b1;
        a8 = 8'd62;
        b8 = 8'd9;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid8 !== 1'b1 || q8 !== 8'd3 || r8 !== 8'd1) begin
            failures++;
            $display("FAIL pre_reset_busy: got v=%b q=%0d r=%0d, want v=1 q=3 r=1",
                     out_valid8, q8, r8);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid8 !== 1'b0 || q8 !== 8'd0 || r8 !== 8'd0 || dbz8 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_clear: got v=%b q=%0d r=%0d dbz=%b, want all zero",
                     out_valid8, q8, r8, dbz8);
        end
        sb8.delete();
        @(negedge clk);
        a8 = 8'd63;
        b8 = 8'd8;
        @(negedge clk);
        a8 = 8'd64;
        b8 = 8'd10;
        @(negedge clk);
        rst = 1'b0;
        issue8(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 1'b1);
        idle8(1);
        drain("reset");

        // Random regression at width 32, mixing b=0, b=1, a<b and general cases.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] av, bv;
            av = $urandom;
            case (i % 5)
                0: bv = 32'd0;
                1: bv = 32'd1;
                2: begin
                    bv = $urandom | 32'd1;
                    av = av % bv;
                end
                3: bv = $urandom >> $urandom_range(31, 0);
                default: bv = $urandom;
            endcase
            issue32(av, bv);
            if (i % 97 == 0) begin
                in_valid32 = 1'b0;
                @(negedge clk);
            end
        end
        in_valid32 = 1'b0;
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
